// File: rtl/complex_dot_pkg.sv
// rtl/complex_dot_pkg.sv - shared types and operand index constants for complex_dot_acc
package complex_dot_pkg;

    // Accumulator stage: no partial sum, partial sum held, result presented.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } acc_state_e;

    // Position of each operand inside one lane's group of four words.
    localparam int X_RE = 0;
    localparam int X_IM = 1;
    localparam int Y_RE = 2;
    localparam int Y_IM = 3;
    localparam int OPS_PER_LANE = 4;

endpackage

// File: rtl/complex_dot_acc_if.sv
// rtl/complex_dot_acc_if.sv - beat/result handshake bundle for complex_dot_acc
// master drives beats and result acceptance; slave is the accumulator side.
interface complex_dot_acc_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 48
) (
    input logic clk_i
);
    logic [LANES*4-1:0][DATA_W-1:0] operands;
    logic [LANES-1:0]               lane_mask;
    logic                           conj;
    logic                           last;
    logic                           in_valid;
    logic                           in_ready;
    logic                           flush;
    logic [1:0][ACC_W-1:0]          result;
    logic                           overflow;
    logic                           out_valid;
    logic                           out_ready;
    logic                           busy;

    modport master (
        input  clk_i,
        output operands, lane_mask, conj, last, in_valid, flush, out_ready,
        input  in_ready, result, overflow, out_valid, busy
    );

    modport slave (
        input  clk_i,
        input  operands, lane_mask, conj, last, in_valid, flush, out_ready,
        output in_ready, result, overflow, out_valid, busy
    );
endinterface

// File: rtl/complex_dot_lane.sv
// rtl/complex_dot_lane.sv - one lane's masked, optionally conjugated complex product
// ops_i: {y_im, y_re, x_im, x_re}; mask_i=0 forces zero; conj_i=1 gives x*conj(y).
// re_o/im_o: full-precision signed products, 2*DATA_W+1 bits.
module complex_dot_lane
    import complex_dot_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [OPS_PER_LANE-1:0][DATA_W-1:0] ops_i,
    input  logic                                mask_i,
    input  logic                                conj_i,
    output logic signed [2*DATA_W:0]            re_o,
    output logic signed [2*DATA_W:0]            im_o
);
    localparam int PW = 2*DATA_W + 1;

    logic signed [DATA_W-1:0] xr, xi, yr, yi;
    logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;

    assign xr = ops_i[X_RE];
    assign xi = ops_i[X_IM];
    assign yr = ops_i[Y_RE];
    assign yi = ops_i[Y_IM];

    // Widen before multiplying; every product magnitude fits in PW bits.
    assign p_rr = PW'(xr) * PW'(yr);
    assign p_ii = PW'(xi) * PW'(yi);
    assign p_ri = PW'(xr) * PW'(yi);
    assign p_ir = PW'(xi) * PW'(yr);

    always_comb begin
        re_o = '0;
        im_o = '0;
        if (mask_i) begin
            if (conj_i) begin
                re_o = p_rr + p_ii;
                im_o = p_ir - p_ri;
            end else begin
                re_o = p_rr - p_ii;
                im_o = p_ri + p_ir;
            end
        end
    end
endmodule

// File: rtl/complex_dot_acc.sv
// rtl/complex_dot_acc.sv - pipelined multi-lane complex dot-product accumulator
// Ports: clk_i/rst_ni (async active-low); operands_i, lane_mask_i, conj_i, last_i,
// in_valid_i/in_ready_o beat input; flush_i abort; result_o, overflow_o,
// out_valid_o/out_ready_i result output; busy_o activity indicator.
module complex_dot_acc
    import complex_dot_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 48
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [LANES*OPS_PER_LANE-1:0][DATA_W-1:0] operands_i,
    input  logic [LANES-1:0]                       lane_mask_i,
    input  logic                                   conj_i,
    input  logic                                   last_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic                                   flush_i,
    output logic [1:0][ACC_W-1:0]                  result_o,
    output logic                                   overflow_o,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic                                   busy_o
);
    localparam int PW = 2*DATA_W + 1;

    if (ACC_W < 2*DATA_W + 1 + $clog2(LANES)) begin : g_acc_w_check
        $error("complex_dot_acc: ACC_W too narrow for lane tree sum");
    end

    logic signed [PW-1:0] lane_re [LANES];
    logic signed [PW-1:0] lane_im [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        complex_dot_lane #(.DATA_W(DATA_W)) u_lane (
            .ops_i  (operands_i[k*OPS_PER_LANE +: OPS_PER_LANE]),
            .mask_i (lane_mask_i[k]),
            .conj_i (conj_i),
            .re_o   (lane_re[k]),
            .im_o   (lane_im[k])
        );
    end

    logic signed [PW-1:0]    s1_re_q [LANES], s1_re_d [LANES];
    logic signed [PW-1:0]    s1_im_q [LANES], s1_im_d [LANES];
    logic                    s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic signed [ACC_W-1:0] s2_re_q, s2_re_d, s2_im_q, s2_im_d;
    logic                    s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    acc_state_e              state_q, state_d;
    logic signed [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic signed [ACC_W-1:0] res_re_q, res_re_d, res_im_q, res_im_d;
    logic                    ovf_q, ovf_d;

    logic                    en, fresh, ovf_re, ovf_im;
    logic signed [ACC_W-1:0] tree_re, tree_im, base_re, base_im, sum_re, sum_im;

    // A presented-but-unaccepted result stalls every stage.
    assign en          = !(out_valid_o && !out_ready_i) && !flush_i;
    assign in_ready_o  = en;
    assign out_valid_o = (state_q == ST_HOLD);
    assign result_o[0] = res_re_q;
    assign result_o[1] = res_im_q;
    assign overflow_o  = ovf_q;
    assign busy_o      = s1_valid_q || s2_valid_q || (state_q != ST_IDLE);

    always_comb begin
        tree_re = '0;
        tree_im = '0;
        for (int k = 0; k < LANES; k++) begin
            tree_re = tree_re + ACC_W'(s1_re_q[k]);
            tree_im = tree_im + ACC_W'(s1_im_q[k]);
        end

        // HOLD counts as a fresh start: when it is released in the same cycle
        // an S2 beat arrives, that beat opens a new dot product.
        fresh   = (state_q != ST_ACCUM);
        base_re = fresh ? '0 : acc_re_q;
        base_im = fresh ? '0 : acc_im_q;
        sum_re  = base_re + s2_re_q;
        sum_im  = base_im + s2_im_q;
        ovf_re  = (base_re[ACC_W-1] == s2_re_q[ACC_W-1]) && (sum_re[ACC_W-1] != base_re[ACC_W-1]);
        ovf_im  = (base_im[ACC_W-1] == s2_im_q[ACC_W-1]) && (sum_im[ACC_W-1] != base_im[ACC_W-1]);
    end

    always_comb begin
        s1_re_d    = s1_re_q;
        s1_im_d    = s1_im_q;
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s2_re_d    = s2_re_q;
        s2_im_d    = s2_im_q;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        state_d    = state_q;
        acc_re_d   = acc_re_q;
        acc_im_d   = acc_im_q;
        res_re_d   = res_re_q;
        res_im_d   = res_im_q;
        ovf_d      = ovf_q;

        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            state_d    = ST_IDLE;
            acc_re_d   = '0;
            acc_im_d   = '0;
            ovf_d      = 1'b0;
        end else if (en) begin
            s1_valid_d = in_valid_i;
            s1_last_d  = last_i;
            s1_re_d    = lane_re;
            s1_im_d    = lane_im;
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_re_d    = tree_re;
            s2_im_d    = tree_im;

            if (state_q == ST_HOLD) begin
                state_d = ST_IDLE;
            end
            if (s2_valid_q) begin
                ovf_d = (!fresh && ovf_q) || ovf_re || ovf_im;
                if (s2_last_q) begin
                    res_re_d = sum_re;
                    res_im_d = sum_im;
                    acc_re_d = '0;
                    acc_im_d = '0;
                    state_d  = ST_HOLD;
                end else begin
                    acc_re_d = sum_re;
                    acc_im_d = sum_im;
                    state_d  = ST_ACCUM;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < LANES; k++) begin
                s1_re_q[k] <= '0;
                s1_im_q[k] <= '0;
            end
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_re_q    <= '0;
            s2_im_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            state_q    <= ST_IDLE;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            res_re_q   <= '0;
            res_im_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_re_q    <= s1_re_d;
            s1_im_q    <= s1_im_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s2_re_q    <= s2_re_d;
            s2_im_q    <= s2_im_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            state_q    <= state_d;
            acc_re_q   <= acc_re_d;
            acc_im_q   <= acc_im_d;
            res_re_q   <= res_re_d;
            res_im_q   <= res_im_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_complex_dot_acc.sv
// tb/tb_complex_dot_acc.sv - scoreboard bench for complex_dot_acc (ACC_W 48 and 35)
module tb_complex_dot_acc;
    import complex_dot_pkg::*;

    localparam int LANES  = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 48;
    localparam int ACC_N  = 35;

    typedef logic [LANES*4-1:0][DATA_W-1:0] ops_t;
    typedef struct { longint re; longint im; bit ovf; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    complex_dot_acc_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus (.clk_i(clk));

    logic [1:0][ACC_N-1:0] n_result;
    logic n_ovf, n_valid, n_ready, n_busy;

    complex_dot_acc #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .operands_i(bus.operands), .lane_mask_i(bus.lane_mask),
        .conj_i(bus.conj), .last_i(bus.last), .in_valid_i(bus.in_valid), .in_ready_o(bus.in_ready),
        .flush_i(bus.flush), .result_o(bus.result), .overflow_o(bus.overflow),
        .out_valid_o(bus.out_valid), .out_ready_i(bus.out_ready), .busy_o(bus.busy)
    );

    complex_dot_acc #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_N)) u_dut_n (
        .clk_i(clk), .rst_ni(rst_n), .operands_i(bus.operands), .lane_mask_i(bus.lane_mask),
        .conj_i(bus.conj), .last_i(bus.last), .in_valid_i(bus.in_valid), .in_ready_o(n_ready),
        .flush_i(bus.flush), .result_o(n_result), .overflow_o(n_ovf),
        .out_valid_o(n_valid), .out_ready_i(bus.out_ready), .busy_o(n_busy)
    );

    int errors = 0;
    int checks = 0;
    exp_t q_w[$];
    exp_t q_n[$];
    longint m_re[2], m_im[2];
    bit     m_ovf[2];
    bit     m_open = 1'b0;
    bit     rand_ready = 1'b0;

    function automatic longint wrapw(longint v, int w);
        longint t;
        t = v <<< (64 - w);
        return t >>> (64 - w);
    endfunction

    function automatic ops_t build(int xr, int xi, int yr, int yi);
        ops_t v;
        for (int k = 0; k < LANES; k++) begin
            v[4*k+X_RE] = DATA_W'(xr);
            v[4*k+X_IM] = DATA_W'(xi);
            v[4*k+Y_RE] = DATA_W'(yr);
            v[4*k+Y_IM] = DATA_W'(yi);
        end
        return v;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact complex arithmetic, then modular accumulation per width.
    task automatic model_accept(ops_t ops, logic [LANES-1:0] mask, bit cj, bit lst);
        longint sr = 0, si = 0;
        for (int k = 0; k < LANES; k++) begin
            longint xr, xi, yr, yi;
            xr = longint'($signed(ops[4*k+X_RE]));
            xi = longint'($signed(ops[4*k+X_IM]));
            yr = longint'($signed(ops[4*k+Y_RE]));
            yi = longint'($signed(ops[4*k+Y_IM]));
            if (mask[k]) begin
                if (cj) begin sr += xr*yr + xi*yi; si += xi*yr - xr*yi; end
                else    begin sr += xr*yr - xi*yi; si += xr*yi + xi*yr; end
            end
        end
        for (int d = 0; d < 2; d++) begin
            int w;
            longint er, ei;
            bit o;
            w  = (d == 0) ? ACC_W : ACC_N;
            er = (m_open ? m_re[d] : 0) + sr;
            ei = (m_open ? m_im[d] : 0) + si;
            o  = (m_open && m_ovf[d]) || (wrapw(er, w) != er) || (wrapw(ei, w) != ei);
            if (lst) begin
                exp_t e;
                e.re = wrapw(er, w); e.im = wrapw(ei, w); e.ovf = o;
                if (d == 0) q_w.push_back(e); else q_n.push_back(e);
                m_re[d] = 0; m_im[d] = 0; m_ovf[d] = 1'b0;
            end else begin
                m_re[d] = wrapw(er, w); m_im[d] = wrapw(ei, w); m_ovf[d] = o;
            end
        end
        m_open = !lst;
    endtask

    task automatic model_clear();
        m_open = 1'b0;
        q_w.delete();
        q_n.delete();
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic drive_beat(ops_t ops, logic [LANES-1:0] mask, bit cj, bit lst);
        int guard = 0;
        bus.operands = ops; bus.lane_mask = mask; bus.conj = cj; bus.last = lst;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready) begin
            @(negedge clk); #1;
            guard++;
            if (guard > 2000) begin
                $display("FAIL accept_timeout: in_ready stuck at %0b required 1", bus.in_ready);
                $fatal(1, "accept timeout");
            end
        end
        @(posedge clk);
        model_accept(ops, mask, cj, lst);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(string name);
        int guard = 0;
        while (!bus.out_valid && guard < 50) begin
            @(negedge clk); #2;
            guard++;
        end
        chk({name, "_out_valid"}, longint'(bus.out_valid), 1);
    endtask

    // Scoreboard monitor: compares whatever the DUTs present against queue heads.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (rst_n && !bus.flush) begin
                if (bus.out_valid) begin
                    if (q_w.size() == 0) begin
                        chk("sb_w_unexpected_result", 1, 0);
                    end else begin
                        chk("sb_w_re", longint'($signed(bus.result[0])), q_w[0].re);
                        chk("sb_w_im", longint'($signed(bus.result[1])), q_w[0].im);
                        chk("sb_w_ovf", longint'(bus.overflow), longint'(q_w[0].ovf));
                        if (bus.out_ready) void'(q_w.pop_front());
                    end
                end
                if (n_valid) begin
                    if (q_n.size() == 0) begin
                        chk("sb_n_unexpected_result", 1, 0);
                    end else begin
                        chk("sb_n_re", longint'($signed(n_result[0])), q_n[0].re);
                        chk("sb_n_im", longint'($signed(n_result[1])), q_n[0].im);
                        chk("sb_n_ovf", longint'(n_ovf), longint'(q_n[0].ovf));
                        if (bus.out_ready) void'(q_n.pop_front());
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        bus.operands = '0; bus.lane_mask = '0; bus.conj = 1'b0; bus.last = 1'b0;
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy_async", longint'(bus.busy), 0);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        rst_n = 1'b1;
        @(negedge clk); #2;
        chk("rst_in_ready", longint'(bus.in_ready), 1);
        chk("rst_result_re", longint'(bus.result[0]), 0);
        chk("rst_overflow", longint'(bus.overflow), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        @(negedge clk);

        // Single beat; latency measured from the accepting edge.
        drive_beat(build(1, 2, 3, 4), 4'hF, 1'b0, 1'b1);
        #2; chk("lat_edge1", longint'(bus.out_valid), 0);
        @(negedge clk); #2; chk("lat_edge2", longint'(bus.out_valid), 0);
        @(negedge clk); #2; chk("lat_edge3", longint'(bus.out_valid), 1);
        chk("mul_re", longint'($signed(bus.result[0])), -20);
        chk("mul_im", longint'($signed(bus.result[1])), 40);
        chk("mul_ovf", longint'(bus.overflow), 0);
        @(negedge clk);

        drive_beat(build(1, 2, 3, 4), 4'hF, 1'b1, 1'b1);
        wait_result("conj");
        chk("conj_re", longint'($signed(bus.result[0])), 44);
        chk("conj_im", longint'($signed(bus.result[1])), 8);
        @(negedge clk);

        drive_beat(build(1, 0, 1, 0), 4'hF, 1'b0, 1'b0);
        drive_beat(build(1, 0, 1, 0), 4'hF, 1'b0, 1'b0);
        drive_beat(build(1, 0, 1, 0), 4'h3, 1'b0, 1'b1);
        wait_result("acc3");
        chk("acc3_re", longint'($signed(bus.result[0])), 10);
        @(negedge clk);
        drive_beat(build(1, 0, 1, 0), 4'h1, 1'b0, 1'b1);
        wait_result("mask1");
        chk("mask1_re", longint'($signed(bus.result[0])), 1);
        chk("mask1_im", longint'($signed(bus.result[1])), 0);
        @(negedge clk);

        // Back-pressure: result must hold while out_ready is low.
        bus.out_ready = 1'b0;
        drive_beat(build(1, 0, 1, 0), 4'hF, 1'b0, 1'b0);
        drive_beat(build(1, 0, 1, 0), 4'hF, 1'b0, 1'b0);
        drive_beat(build(1, 0, 1, 0), 4'h3, 1'b0, 1'b1);
        wait_result("stall");
        for (int i = 0; i < 10; i++) begin
            chk("stall_in_ready", longint'(bus.in_ready), 0);
            chk("stall_result", longint'($signed(bus.result[0])), 10);
            @(negedge clk); #2;
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive_beat(build(2, 0, 2, 0), 4'hF, 1'b0, 1'b1);
        wait_result("after_stall");
        chk("after_stall_re", longint'($signed(bus.result[0])), 16);
        @(negedge clk);

        // Overflow of the 35-bit accumulator; 48-bit instance must stay clean.
        for (int b = 0; b < 3; b++)
            drive_beat(build(-32768, -32768, -32768, 32767), 4'hF, 1'b0, (b == 2));
        wait_result("ovf");
        chk("ovf_n_flag", longint'(n_ovf), 1);
        chk("ovf_n_re", longint'($signed(n_result[0])), -64'sd8590327808);
        chk("ovf_w_flag", longint'(bus.overflow), 0);
        chk("ovf_w_re", longint'($signed(bus.result[0])), 64'sd25769410560);
        chk("ovf_w_im", longint'($signed(bus.result[1])), 393216);
        @(negedge clk);

        // Flush mid dot product; the beat offered during the flush is ignored.
        drive_beat(build(5, 1, 3, 2), 4'hF, 1'b0, 1'b0);
        drive_beat(build(5, 1, 3, 2), 4'hF, 1'b0, 1'b0);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.last = 1'b1;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        #2;
        chk("flush_busy", longint'(bus.busy), 0);
        @(negedge clk);
        drive_beat(build(2, 0, 2, 0), 4'hF, 1'b0, 1'b1);
        wait_result("flush");
        chk("flush_re", longint'($signed(bus.result[0])), 16);
        chk("flush_im", longint'($signed(bus.result[1])), 0);
        @(negedge clk);

        // Asynchronous reset mid dot product.
        drive_beat(build(7, 3, 1, 9), 4'hF, 1'b1, 1'b0);
        drive_beat(build(7, 3, 1, 9), 4'hF, 1'b1, 1'b0);
        #3; rst_n = 1'b0;
        #1; chk("areset_busy", longint'(bus.busy), 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_beat(build(2, 0, 2, 0), 4'hF, 1'b0, 1'b1);
        wait_result("areset");
        chk("areset_re", longint'($signed(bus.result[0])), 16);
        @(negedge clk);

        // Randomized traffic under random back-pressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            ops_t ops;
            for (int i = 0; i < LANES*4; i++) ops[i] = DATA_W'($urandom);
            drive_beat(ops, LANES'($urandom), 1'($urandom), (n == 299) || ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        begin
            int guard = 0;
            while ((q_w.size() != 0 || q_n.size() != 0) && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
        end
        chk("drain_w", longint'(q_w.size()), 0);
        chk("drain_n", longint'(q_n.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/complex_dot_acc.md
COMPLEX_DOT_ACC -- requirements
Module: complex_dot_acc

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel complex lanes (power of two, >=1).
REQ-002 SHALL have parameter DATA_W, default 16, signed two's-complement width of each real/imag operand.
REQ-003 SHALL have parameter ACC_W, default 48, accumulator/result width; elaboration SHALL fail if ACC_W < 2*DATA_W+1+$clog2(LANES).
REQ-004 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port operands_i  input  [LANES*4-1:0][DATA_W-1:0]  lane k: [4k]=x_re, [4k+1]=x_im, [4k+2]=y_re, [4k+3]=y_im.
REQ-007 SHALL have port lane_mask_i  input  LANES  1 = lane contributes this beat; 0 = lane contributes zero.
REQ-008 SHALL have port conj_i  input  1  per-beat mode; 1 = x*conj(y), 0 = x*y.
REQ-009 SHALL have port last_i  input  1  marks final beat of a dot product.
REQ-010 SHALL have ports in_valid_i input 1 and in_ready_o output 1  input handshake; beat accepted when both high on a rising edge.
REQ-011 SHALL have port flush_i  input  1  synchronous abort of all in-flight work.
REQ-012 SHALL have port result_o  output  [1:0][ACC_W-1:0]  [0]=re, [1]=im of completed dot product.
REQ-013 SHALL have port overflow_o  output  1  sticky signed-overflow flag for the result, valid with out_valid_o.
REQ-014 SHALL have ports out_valid_o output 1 and out_ready_i input 1  output handshake.
REQ-015 SHALL have port busy_o  output  1  high while any beat, partial sum or result is held.

Function
REQ-016 Per-lane product: conj_i=0 -> re=xr*yr-xi*yi, im=xr*yi+xi*yr; conj_i=1 -> re=xr*yr+xi*yi, im=xi*yr-xr*yi; full precision, sign-extended to ACC_W.
REQ-017 Pipeline: S1 registers per-lane products (masked lanes = 0); S2 registers the lane adder-tree sum; S3 accumulates.
REQ-018 Global enable en = !(out_valid_o && !out_ready_i) && !flush_i; in_ready_o = en; all stages advance only when en.
REQ-019 Latency: with en held high, out_valid_o rises after the 3rd rising edge, counting the edge that accepts the last_i beat as the 1st.
REQ-020 Accumulator FSM: IDLE (no partial sum), ACCUM (partial sum held), HOLD (result presented).
REQ-021 IDLE/ACCUM + S2 beat with last=0 -> acc = (IDLE ? 0 : acc) + sum, go ACCUM.
REQ-022 IDLE/ACCUM + S2 beat with last=1 -> result_o = (IDLE ? 0 : acc) + sum, out_valid_o=1, acc cleared, go HOLD.
REQ-023 HOLD + out_ready_i=1 -> out_valid_o=0 next cycle, go IDLE; pipeline resumes in the same cycle (en=1).
REQ-024 result_o and overflow_o SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-025 Accumulation wraps modulo 2^ACC_W; overflow_o is set if any accumulate addition of that dot product overflows signed ACC_W, cleared at the first beat of the next dot product.
REQ-026 A last_i beat with lane_mask_i=0 SHALL still complete: result equals prior partial sum (0 from IDLE).
REQ-027 conj_i and lane_mask_i are sampled per beat and may change between beats of one dot product.
REQ-028 flush_i=1: next edge clears all stage valids, acc, overflow, out_valid_o; FSM -> IDLE; inputs that cycle ignored.
REQ-029 busy_o = any S1/S2 valid OR FSM != IDLE.

Reset
REQ-030 rst_ni low SHALL asynchronously force FSM=IDLE, all stage valids=0, acc=0, result_o=0, overflow_o=0, out_valid_o=0, busy_o=0; in_ready_o=1 after release.
REQ-031 Reset mid-dot-product SHALL discard all partial work; no out_valid_o until a new last_i beat completes.

Structure
REQ-032 Shared package complex_dot_pkg SHALL hold the FSM state enum and the operand index constants (X_RE=0, X_IM=1, Y_RE=2, Y_IM=3).
REQ-033 One sub-module complex_dot_lane SHALL implement one lane's masked/conjugated product (combinational), instantiated LANES times; tree and FSM stay in top.

Verification (LANES=4, DATA_W=16 unless noted)
REQ-034 One beat, mask 1111, last=1, conj=0, all lanes x=(1,2), y=(3,4) -> result (-20,40), overflow 0, out_valid 3 edges after accept.
REQ-035 Same with conj=1 -> result (44,8).
REQ-036 Three beats x=(1,0), y=(1,0); masks 1111,1111,0011; last on 3rd -> result (10,0); next single beat x=y=(1,0) mask 0001 -> (1,0).
REQ-037 Hold out_ready_i=0 after result: in_ready_o=0, result_o stable 10 cycles; raise out_ready_i -> handshake, next dot product starts from 0.
REQ-038 ACC_W=35, three beats all lanes x=(-32768,-32768), y=(-32768,32767), conj=0 -> overflow_o=1, result_o re = 25769410560 mod 2^35 as signed.
REQ-039 Two beats accumulated, flush_i one cycle, then one beat x=y=(2,0) mask 1111 last=1 -> only result (16,0); likewise for rst_ni pulse mid-dot-product.
